// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter_if
// Brief    : Requester A/B handshake, read return and SRAM wrapper bus.
// Revision : 1.0
// ============================================================================
interface sram_port_arbiter_if #(
   parameter int ADDR_W = 14
);
   logic [2:0]        conf_in;

   logic              a_req_valid;
   logic              a_req_ready;
   logic              a_req_we;
   logic [ADDR_W-1:0] a_req_addr;
   logic [31:0]       a_req_wdata;
   logic              b_req_valid;
   logic              b_req_ready;
   logic              b_req_we;
   logic [ADDR_W-1:0] b_req_addr;
   logic [31:0]       b_req_wdata;

   logic              a_rvalid;
   logic [31:0]       a_rdata;
   logic              b_rvalid;
   logic [31:0]       b_rdata;
   logic              busy;

   logic              sram_csb;
   logic              sram_web;
   logic              sram_reb;
   logic [ADDR_W-1:0] sram_addr_w;
   logic [ADDR_W-1:0] sram_addr_r;
   logic [31:0]       sram_d_in;
   logic [2:0]        sram_conf;
   logic [31:0]       sram_d_out;

   modport slave (
      input  conf_in,
      input  a_req_valid, a_req_we, a_req_addr, a_req_wdata,
      input  b_req_valid, b_req_we, b_req_addr, b_req_wdata,
      output a_req_ready, b_req_ready,
      output a_rvalid, a_rdata, b_rvalid, b_rdata, busy,
      output sram_csb, sram_web, sram_reb,
      output sram_addr_w, sram_addr_r, sram_d_in, sram_conf,
      input  sram_d_out
   );

   modport master (
      output conf_in,
      output a_req_valid, a_req_we, a_req_addr, a_req_wdata,
      output b_req_valid, b_req_we, b_req_addr, b_req_wdata,
      input  a_req_ready, b_req_ready,
      input  a_rvalid, a_rdata, b_rvalid, b_rdata, busy,
      input  sram_csb, sram_web, sram_reb,
      input  sram_addr_w, sram_addr_r, sram_d_in, sram_conf,
      output sram_d_out
   );
endinterface

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Round-robin write/read arbiter for a 1W/1R SRAM wrapper with
//            tagged read-data return to requester A or B.
// Revision : 1.0
// ============================================================================
module sram_port_arbiter #(
   parameter int READ_LAT = 3,
   parameter int ADDR_W   = 14
) (
   input  logic               clk,
   input  logic               rst_n,
   sram_port_arbiter_if.slave bus
);

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

   localparam int BASE_W = 9;

   logic              wr_cand_a, wr_cand_b;
   logic              rd_cand_a, rd_cand_b;
   logic              wr_gnt_a, wr_gnt_b, wr_any;
   logic              rd_pick_a, rd_pick_b, rd_pick_any;
   logic              rd_gnt_a, rd_gnt_b, rd_any;
   logic              hazard;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic              tail_vld, tail_is_b;

   req_id_e           wr_ptr_q, wr_ptr_d;
   req_id_e           rd_ptr_q, rd_ptr_d;
   logic [READ_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [READ_LAT-1:0] tag_id_q,  tag_id_d;

   assign wr_cand_a = bus.a_req_valid &  bus.a_req_we;
   assign wr_cand_b = bus.b_req_valid &  bus.b_req_we;
   assign rd_cand_a = bus.a_req_valid & ~bus.a_req_we;
   assign rd_cand_b = bus.b_req_valid & ~bus.b_req_we;

   // Grants are gated by rst_n so nothing is accepted while reset is held.
   assign wr_gnt_a = rst_n & wr_cand_a & (~wr_cand_b | (wr_ptr_q == REQ_A));
   assign wr_gnt_b = rst_n & wr_cand_b & (~wr_cand_a | (wr_ptr_q == REQ_B));
   assign wr_any   = wr_gnt_a | wr_gnt_b;

   assign rd_pick_a   = rst_n & rd_cand_a & (~rd_cand_b | (rd_ptr_q == REQ_A));
   assign rd_pick_b   = rst_n & rd_cand_b & (~rd_cand_a | (rd_ptr_q == REQ_B));
   assign rd_pick_any = rd_pick_a | rd_pick_b;

   assign wr_addr = wr_gnt_b  ? bus.b_req_addr : bus.a_req_addr;
   assign rd_addr = rd_pick_b ? bus.b_req_addr : bus.a_req_addr;

   // Same-base-address read would race the write inside the macro: hold it off.
   assign hazard = wr_any & rd_pick_any &
                   (wr_addr[BASE_W-1:0] == rd_addr[BASE_W-1:0]);

   assign rd_gnt_a = rd_pick_a & ~hazard;
   assign rd_gnt_b = rd_pick_b & ~hazard;
   assign rd_any   = rd_gnt_a | rd_gnt_b;

   assign bus.a_req_ready = wr_gnt_a | rd_gnt_a;
   assign bus.b_req_ready = wr_gnt_b | rd_gnt_b;

   assign bus.sram_csb    = ~(wr_any | rd_any);
   assign bus.sram_web    = ~wr_any;
   assign bus.sram_reb    = ~rd_any;
   assign bus.sram_addr_w = wr_any ? wr_addr : '0;
   assign bus.sram_addr_r = rd_any ? rd_addr : '0;
   assign bus.sram_d_in   = wr_gnt_a ? bus.a_req_wdata :
                            wr_gnt_b ? bus.b_req_wdata : 32'd0;
   assign bus.sram_conf   = bus.conf_in;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_gnt_a) begin
         wr_ptr_d = REQ_B;
      end else if (wr_gnt_b) begin
         wr_ptr_d = REQ_A;
      end
      if (rd_gnt_a) begin
         rd_ptr_d = REQ_B;
      end else if (rd_gnt_b) begin
         rd_ptr_d = REQ_A;
      end
   end

   // Stage 0 holds the read accepted last cycle; the top stage is returning now.
   assign tag_vld_d = {tag_vld_q[READ_LAT-2:0], rd_any};
   assign tag_id_d  = {tag_id_q[READ_LAT-2:0],  rd_gnt_b};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= REQ_A;
         rd_ptr_q  <= REQ_A;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
      end
   end

   assign tail_vld  = rst_n & tag_vld_q[READ_LAT-1];
   assign tail_is_b = tag_id_q[READ_LAT-1];

   assign bus.a_rvalid = tail_vld & ~tail_is_b;
   assign bus.b_rvalid = tail_vld &  tail_is_b;
   assign bus.a_rdata  = bus.a_rvalid ? bus.sram_d_out : 32'd0;
   assign bus.b_rdata  = bus.b_rvalid ? bus.sram_d_out : 32'd0;
   assign bus.busy     = rst_n & (|tag_vld_q);

endmodule

`default_nettype wire
